// File: rtl/mutative_predictor_pkg.sv
// Shared types for the mutative predictor: FSM states, vote encoding and setup bounds.
package mutative_types;

  typedef enum logic [1:0] {
    P_COUNT,
    P_REQ,
    P_SETTLE,
    P_DRAIN
  } mutative_pred_state_t;

  typedef enum logic [1:0] {
    NONE,
    UP,
    DOWN
  } mutative_vote_t;

  localparam logic [1:0]  SETUP_MAX = 2'd3;
  localparam int unsigned STREAK_W  = 4;

endpackage

// File: rtl/mutative_predictor_sat_counter.sv
// Saturating incrementer with synchronous clear and load; clear has priority over load over increment.
module mutative_sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mutative_predictor.sv
// Miss-rate policy stage: counts misses per epoch, votes, and requests setup steps after HYST agreeing epochs.
module mutative_predictor
  import mutative_types::*;
#(
  parameter int unsigned EPOCH_LEN = 1024,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned HI_THRESH = 256,
  parameter int unsigned LO_THRESH = 32,
  parameter int unsigned HYST      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 access_valid,
  input  logic                 access_hit,
  input  logic [1:0]           setup,
  input  logic                 flush_stall,
  input  logic                 setup_ready,
  output logic                 setup_valid,
  output logic                 setup_update,
  output logic [CNT_WIDTH-1:0] epoch_misses,
  output logic                 busy
);

  localparam int unsigned AW = $clog2(EPOCH_LEN);

  mutative_pred_state_t state, state_nxt;
  mutative_vote_t       vote, last_vote;

  logic [AW-1:0]        acc_cnt;
  logic [CNT_WIDTH-1:0] miss_cnt, total;
  logic [STREAK_W-1:0]  streak, streak_inc, streak_new;
  logic                 count, miss, epoch_end, trigger, drain_exit;

  assign count      = (state == P_COUNT) && access_valid && !flush_stall;
  assign miss       = count && !access_hit;
  assign epoch_end  = count && (acc_cnt == '1);
  assign drain_exit = (state == P_DRAIN) && !flush_stall;

  // miss_cnt never exceeds EPOCH_LEN-1, so adding the current miss cannot overflow
  assign total = miss_cnt + {{(CNT_WIDTH-1){1'b0}}, miss};

  always_comb begin
    vote = NONE;
    if ((total > CNT_WIDTH'(HI_THRESH)) && (setup < SETUP_MAX)) begin
      vote = UP;
    end else if ((total < CNT_WIDTH'(LO_THRESH)) && (setup > 2'd0)) begin
      vote = DOWN;
    end
  end

  assign streak_inc = (streak == '1) ? streak : streak + 1'b1;

  always_comb begin
    streak_new = '0;
    if (vote != NONE) begin
      streak_new = (vote != last_vote) ? STREAK_W'(1) : streak_inc;
    end
  end

  assign trigger = epoch_end && (vote != NONE) && (streak_new >= STREAK_W'(HYST));

  mutative_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .clr (epoch_end || drain_exit),
    .ld  (1'b0),
    .d   ('0),
    .en  (miss),
    .q   (miss_cnt)
  );

  // same streak_new result, expressed as clear / load-1 / saturating increment
  mutative_sat_counter #(.WIDTH(STREAK_W)) u_streak (
    .clk (clk),
    .rst (rst),
    .clr (trigger || (epoch_end && (vote == NONE))),
    .ld  (epoch_end && (vote != last_vote)),
    .d   (STREAK_W'(1)),
    .en  (epoch_end),
    .q   (streak)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= P_COUNT;
      acc_cnt      <= '0;
      last_vote    <= NONE;
      epoch_misses <= '0;
      setup_update <= 1'b0;
    end else begin
      state <= state_nxt;
      if (drain_exit) begin
        acc_cnt <= '0;
      end else if (count) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (epoch_end) begin
        epoch_misses <= total;
        last_vote    <= trigger ? NONE : vote;
      end
      if (trigger) begin
        setup_update <= (vote == UP);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      P_COUNT:  if (trigger)      state_nxt = P_REQ;
      P_REQ:    if (setup_ready)  state_nxt = P_SETTLE;
      P_SETTLE:                   state_nxt = P_DRAIN;
      P_DRAIN:  if (!flush_stall) state_nxt = P_COUNT;
      default:                    state_nxt = P_COUNT;
    endcase
  end

  assign setup_valid = (state == P_REQ);
  assign busy        = (state != P_COUNT);

endmodule

// File: tb/tb_mutative_predictor.sv
// Self-checking bench: directed vector table plus randomized traffic against an epoch-level reference model.
module tb_mutative_predictor;

  localparam int EL = 16;
  localparam int CW = 8;
  localparam int HI = 8;
  localparam int LO = 2;
  localparam int HY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          access_valid = 1'b0;
  logic          access_hit = 1'b0;
  logic [1:0]    setup = 2'd0;
  logic          flush_stall = 1'b0;
  logic          setup_ready = 1'b0;
  logic          setup_valid;
  logic          setup_update;
  logic [CW-1:0] epoch_misses;
  logic          busy;

  mutative_predictor #(
    .EPOCH_LEN (EL),
    .CNT_WIDTH (CW),
    .HI_THRESH (HI),
    .LO_THRESH (LO),
    .HYST      (HY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .access_valid (access_valid),
    .access_hit   (access_hit),
    .setup        (setup),
    .flush_stall  (flush_stall),
    .setup_ready  (setup_ready),
    .setup_valid  (setup_valid),
    .setup_update (setup_update),
    .epoch_misses (epoch_misses),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase 0 counting, 1 requesting, 2 settling, 3 draining
  int m_phase, m_acc, m_miss, m_last, m_run, m_upd, m_em;

  typedef struct {
    int reps;
    bit av;
    bit hit;
    int su;
    bit fs;
    bit rdy;
    bit ev;
    bit eu;
    bit eb;
    int em;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_acc = 0; m_miss = 0; m_last = 0; m_run = 0; m_upd = 0; m_em = 0;
  endtask

  // votes: 0 none, 1 up, 2 down
  task automatic model_step(input bit av, input bit hit, input int su, input bit fs, input bit rdy);
    int vote;
    case (m_phase)
      0: if (av && !fs) begin
        m_acc++;
        if (!hit && m_miss < (1 << CW) - 1) m_miss++;
        if (m_acc == EL) begin
          m_em = m_miss;
          vote = (m_miss > HI && su < 3) ? 1 : (m_miss < LO && su > 0) ? 2 : 0;
          if (vote == 0)           m_run = 0;
          else if (vote == m_last) m_run = (m_run < 15) ? m_run + 1 : 15;
          else                     m_run = 1;
          m_last = vote;
          m_acc = 0;
          m_miss = 0;
          if (vote != 0 && m_run >= HY) begin
            m_phase = 1;
            m_upd = (vote == 1);
            m_run = 0;
            m_last = 0;
          end
        end
      end
      1: if (rdy) m_phase = 2;
      2: m_phase = 3;
      default: if (!fs) begin
        m_phase = 0;
        m_acc = 0;
        m_miss = 0;
      end
    endcase
  endtask

  task automatic step(input bit av, input bit hit, input int su, input bit fs, input bit rdy);
    @(negedge clk);
    access_valid = av;
    access_hit   = hit;
    setup        = su[1:0];
    flush_stall  = fs;
    setup_ready  = rdy;
    @(posedge clk);
    model_step(av, hit, su, fs, rdy);
    #1;
    check("model_valid", int'(setup_valid), int'(m_phase == 1));
    check("model_busy", int'(busy), int'(m_phase != 0));
    check("model_em", int'(epoch_misses), m_em);
    if (m_phase == 1) check("model_update", int'(setup_update), m_upd);
  endtask

  task automatic add(input int reps, input bit av, input bit hit, input int su, input bit fs,
                     input bit rdy, input bit ev, input bit eu, input bit eb, input int em);
    vec_t v;
    v = '{reps, av, hit, su, fs, rdy, ev, eu, eb, em};
    tbl.push_back(v);
  endtask

  initial begin
    int missrate;
    int su;
    bit fs;

    model_reset();
    #12;
    check("reset_valid", int'(setup_valid), 0);
    check("reset_update", int'(setup_update), 0);
    check("reset_em", int'(epoch_misses), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;

    //  reps av hit su fs rdy | valid upd busy em
    add(15, 1, 0, 0, 0, 0, 0, 0, 0, 0);    // threshold crossing: UP, UP
    add(1,  1, 0, 0, 0, 0, 0, 0, 0, 16);
    add(15, 1, 0, 0, 0, 0, 0, 0, 0, 16);
    add(1,  1, 0, 0, 0, 0, 1, 1, 1, 16);   // request visible one cycle after 32nd access
    add(5,  1, 0, 0, 0, 0, 1, 1, 1, 16);   // backpressure, accesses ignored
    add(1,  1, 0, 0, 0, 1, 0, 1, 1, 16);   // handshake -> settle
    add(1,  0, 0, 0, 1, 0, 0, 1, 1, 16);   // settle -> drain
    add(19, 0, 0, 0, 1, 0, 0, 1, 1, 16);   // drain holds while flushing
    add(1,  0, 0, 0, 0, 0, 0, 1, 0, 16);   // back to counting
    add(12, 1, 1, 1, 0, 0, 0, 1, 0, 16);   // fresh epoch: 4 misses -> NONE
    add(4,  1, 0, 1, 0, 0, 0, 1, 0, 4);
    add(16, 1, 0, 1, 0, 0, 0, 1, 0, 16);   // alternating: UP, NONE, UP
    add(12, 1, 1, 1, 0, 0, 0, 1, 0, 16);
    add(4,  1, 0, 1, 0, 0, 0, 1, 0, 4);
    add(16, 1, 0, 1, 0, 0, 0, 1, 0, 16);
    add(64, 1, 0, 3, 0, 0, 0, 1, 0, 16);   // setup saturated high
    add(32, 1, 1, 0, 0, 0, 0, 1, 0, 0);    // setup saturated low
    add(7,  1, 0, 0, 0, 0, 0, 1, 0, 0);    // stall freeze at acc_cnt=7
    add(10, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    add(8,  1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1,  1, 0, 0, 0, 0, 0, 1, 0, 16);   // 9th access after stall ends the epoch
    add(16, 1, 1, 2, 0, 0, 0, 1, 0, 0);    // DOWN, DOWN
    add(15, 1, 1, 2, 0, 0, 0, 1, 0, 0);
    add(1,  1, 0, 2, 0, 0, 1, 0, 1, 1);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++)
        step(tbl[i].av, tbl[i].hit, tbl[i].su, tbl[i].fs, tbl[i].rdy);
      check($sformatf("row%0d_valid", i), int'(setup_valid), int'(tbl[i].ev));
      if (tbl[i].ev) check($sformatf("row%0d_update", i), int'(setup_update), int'(tbl[i].eu));
      check($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].eb));
      check($sformatf("row%0d_em", i), int'(epoch_misses), tbl[i].em);
    end

    // asynchronous reset while the request is pending
    @(negedge clk);
    access_valid = 1'b0;
    setup_ready  = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_valid", int'(setup_valid), 0);
    check("async_busy", int'(busy), 0);
    check("async_em", int'(epoch_misses), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_em", int'(epoch_misses), 0);

    // randomized traffic
    missrate = 50;
    su = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: missrate = 95;
          1: missrate = 3;
          default: missrate = 40;
        endcase
      end
      if ($urandom_range(0, 49) == 0) su = $urandom_range(0, 3);
      if (m_phase == 3) fs = ($urandom_range(0, 3) != 0);
      else              fs = ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 99) >= missrate, su, fs,
           $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mutative_predictor.md
Name: mutative_predictor

Overview:
- Upstream policy stage for mutative_control. It watches the cache access stream and counts misses over fixed-length epochs.
- When enough consecutive epochs agree, it requests one step up or one step down of the cache setup. The request uses the setup_valid/setup_ready/setup_update handshake.
- It freezes while mutative_control is flushing, so that flush traffic never pollutes the statistics.

Parameters:
- EPOCH_LEN, 1024, accepted accesses per epoch. Must be a power of two and at least 2.
- CNT_WIDTH, 16, width of the miss counter. Must satisfy 2^CNT_WIDTH > EPOCH_LEN.
- HI_THRESH, 256, epoch miss count strictly above this value votes UP.
- LO_THRESH, 32, epoch miss count strictly below this value votes DOWN. Must be <= HI_THRESH.
- HYST, 2, number of consecutive identical non-neutral votes required to issue a request. Range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low. The block is in reset while rst==0.
- access_valid  in  1  one cache access completes this cycle.
- access_hit  in  1  qualifies access_valid: 1 = hit, 0 = miss.
- setup  in  2  current setup from mutative_control, in range 0..3.
- flush_stall  in  1  mutative_control is flushing.
- setup_ready  in  1  mutative_control accepts a request.
- setup_valid  out  1  request pending.
- setup_update  out  1  request direction: 1 = increment setup, 0 = decrement.
- epoch_misses  out  CNT_WIDTH  registered miss count of the last completed epoch (debug).
- busy  out  1  high in any state other than P_COUNT.

Behaviour:
- Reset (rst==0, asynchronous): state=P_COUNT; all counters and the streak cleared; last_vote=NONE.
  - Reset values of outputs: setup_valid=0, setup_update=0, epoch_misses=0, busy=0.
  - Asserting rst mid-request drops setup_valid immediately, with no handshake completion.
- States:
  - P_COUNT: counts accesses.
  - P_REQ: drives the request.
  - P_SETTLE: one fixed cycle.
  - P_DRAIN: waits for the flush to finish.
- P_COUNT:
  - An access counts only when access_valid==1 and flush_stall==0.
  - A counted access increments acc_cnt, which is $clog2(EPOCH_LEN) bits wide and wraps.
  - A counted miss increments miss_cnt, saturating at 2^CNT_WIDTH-1.
  - The epoch ends on the counted access that makes acc_cnt wrap to 0. That access belongs to the ending epoch.
- Epoch end, computed combinationally on the ending access and registered that cycle:
  - total = miss_cnt plus the current miss.
  - epoch_misses <= total.
  - Vote: UP if total > HI_THRESH and setup < 3; DOWN if total < LO_THRESH and setup > 0; otherwise NONE. UP has priority if both conditions could hold.
- Streak update at epoch end:
  - If vote==NONE or vote!=last_vote: streak <= (vote==NONE ? 0 : 1).
  - Otherwise streak <= streak+1, saturating at 15.
  - last_vote <= vote.
  - miss_cnt <= 0.
- Request trigger: if the new streak value reaches HYST, go to P_REQ next cycle. Latency is ending access at cycle N, setup_valid=1 at N+1.
  - setup_update = (vote==UP) is registered and held stable.
  - streak and last_vote are cleared.
- P_REQ:
  - setup_valid=1; setup_update is constant.
  - Accesses are ignored.
  - Stay until setup_ready==1 in the same cycle; that cycle is the handshake.
  - setup_valid may not drop before the handshake.
  - Go to P_SETTLE next cycle with setup_valid=0.
- P_SETTLE: exactly one cycle, which covers mutative_control's registered stall onset. Then go to P_DRAIN.
- P_DRAIN:
  - Stay while flush_stall==1.
  - On flush_stall==0, return to P_COUNT with acc_cnt=0 and miss_cnt=0, starting a fresh epoch.
- flush_stall==1 in P_COUNT (a flush started elsewhere): counters hold their values; nothing is cleared.
- access_hit is don't-care when access_valid==0.
- setup is sampled only at epoch end. It is not re-checked in P_REQ; mutative_control already saturates the setup.

Decomposition:
- Add to the mutative_types package:
  - the predictor state enum mutative_pred_state_t (P_COUNT, P_REQ, P_SETTLE, P_DRAIN);
  - the vote enum mutative_vote_t (NONE, UP, DOWN);
  - the constant SETUP_MAX=3.
- One natural sub-module: mutative_sat_counter, a parameterised-width saturating incrementer with synchronous clear and enable. It is used for miss_cnt and streak.

Test Plan:
- Threshold-crossing request: EPOCH_LEN=16, HI=8, LO=2, HYST=2, setup=0; 32 counted misses -> epoch_misses=16 after each epoch; setup_valid=1 with setup_update=1 exactly one cycle after the 32nd access.
- Alternating votes cancel: epochs of 16 misses, 4 misses, 16 misses, setup=1 -> votes UP, NONE, UP; streak never reaches 2; setup_valid stays 0.
- Saturated setup: setup=3 with 16/16 misses for 4 epochs -> vote NONE every epoch; no request. setup=0 with 0 misses -> no DOWN request.
- Backpressure: request pending, setup_ready=0 for 5 cycles with access_valid=1 every cycle -> setup_valid and setup_update stable; miss_cnt unchanged. Handshake on cycle 6; then P_SETTLE for 1 cycle; P_DRAIN while flush_stall=1 for 20 cycles; then a fresh epoch.
- Stall freeze: flush_stall=1 for 10 cycles at acc_cnt=7, with accesses offered -> acc_cnt and miss_cnt held. The epoch ends only after 9 more counted accesses once the stall drops.
- Async reset in P_REQ: rst=0 mid-cycle -> setup_valid=0 and busy=0 without waiting for a clock edge; after release, epoch_misses=0 and state is P_COUNT.
